// File: rtl/mem_stage_dataif.sv
// MEM-stage data-memory interface: builds word-addressed byte-enabled requests,
// runs the wait-state handshake, formats load data and flags misaligned accesses.
module mem_stage_dataif #(
  parameter int unsigned ADDR_W = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              M_MemRead,
  input  logic              M_MemWrite,
  input  logic              M_MemByte,
  input  logic              M_MemHalf,
  input  logic              M_MemSignExtend,
  input  logic [31:0]       M_ALU_Result,
  input  logic [31:0]       M_WriteData,
  input  logic              M_Flush,
  input  logic              M_StallExt,
  input  logic [31:0]       DataMem_In,
  input  logic              DataMem_Ready,
  output logic [ADDR_W-1:0] DataMem_Address,
  output logic              DataMem_Read,
  output logic [3:0]        DataMem_Write,
  output logic [31:0]       DataMem_Out,
  output logic [31:0]       M_ReadData,
  output logic              M_Stall_Mem,
  output logic              M_EXC_AdEL,
  output logic              M_EXC_AdES
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                abort_q, abort_d;
  logic                capture;

  // Latched copy of the request held stable while memory inserts wait states
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          off_q;
  logic                byte_q, half_q, sign_q, read_q;
  logic [LANES-1:0]    we_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                m_byte, m_half, m_word, m_access, m_misaligned;
  logic [1:0]          m_off;
  logic [LANES-1:0]    m_lanes;
  logic [DATA_W-1:0]   m_wdata;

  // Big-endian lane extraction with optional sign extension
  function automatic logic [DATA_W-1:0] fmt_load(
    input logic [DATA_W-1:0] d,
    input logic [1:0]        off,
    input logic              is_byte,
    input logic              is_half,
    input logic              sx
  );
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    if (is_byte)      r = {{24{sx & b[7]}}, b};
    else if (is_half) r = {{16{sx & h[15]}}, h};
    else              r = d;
    return r;
  endfunction

  assign m_byte       = M_MemByte;
  assign m_half       = ~M_MemByte & M_MemHalf;
  assign m_word       = ~M_MemByte & ~M_MemHalf;
  assign m_off        = M_ALU_Result[1:0];
  assign m_access     = M_MemRead | M_MemWrite;
  assign m_misaligned = (m_half & m_off[0]) | (m_word & (|m_off));

  always_comb begin
    m_lanes = 4'b1111;
    if (m_byte)      m_lanes = 4'b1000 >> m_off;
    else if (m_half) m_lanes = m_off[1] ? 4'b0011 : 4'b1100;
  end

  always_comb begin
    m_wdata = M_WriteData;
    if (m_byte)      m_wdata = {4{M_WriteData[7:0]}};
    else if (m_half) m_wdata = {2{M_WriteData[15:0]}};
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      abort_q <= 1'b0;
      addr_q  <= '0;
      off_q   <= '0;
      byte_q  <= 1'b0;
      half_q  <= 1'b0;
      sign_q  <= 1'b0;
      read_q  <= 1'b0;
      we_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      abort_q <= abort_d;
      if (capture) begin
        addr_q  <= M_ALU_Result[ADDR_W+1:2];
        off_q   <= m_off;
        byte_q  <= m_byte;
        half_q  <= m_half;
        sign_q  <= M_MemSignExtend;
        read_q  <= M_MemRead;
        we_q    <= M_MemWrite ? m_lanes : 4'b0000;
        wdata_q <= m_wdata;
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d         = state_q;
    hold_d          = hold_q;
    abort_d         = abort_q;
    capture         = 1'b0;
    DataMem_Address = '0;
    DataMem_Read    = 1'b0;
    DataMem_Write   = 4'b0000;
    DataMem_Out     = '0;
    M_ReadData      = '0;
    M_Stall_Mem     = 1'b0;
    M_EXC_AdEL      = 1'b0;
    M_EXC_AdES      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m_access && !M_Flush) begin
          if (m_misaligned) begin
            M_EXC_AdEL = M_MemRead;
            M_EXC_AdES = M_MemWrite;
          end else begin
            DataMem_Address = M_ALU_Result[ADDR_W+1:2];
            DataMem_Read    = M_MemRead;
            DataMem_Write   = M_MemWrite ? m_lanes : 4'b0000;
            DataMem_Out     = m_wdata;
            if (DataMem_Ready) begin
              if (M_MemRead)
                M_ReadData = fmt_load(DataMem_In, m_off, m_byte, m_half, M_MemSignExtend);
            end else begin
              capture     = 1'b1;
              M_Stall_Mem = 1'b1;
              abort_d     = 1'b0;
              state_d     = S_WAIT;
            end
          end
        end
      end

      S_WAIT: begin
        DataMem_Address = addr_q;
        DataMem_Read    = read_q;
        DataMem_Write   = we_q;
        DataMem_Out     = wdata_q;
        abort_d         = abort_q | M_Flush;
        if (DataMem_Ready) begin
          abort_d = 1'b0;
          // A flushed access still has to drain on the bus; its result is dropped
          if (abort_q || M_Flush) begin
            state_d = S_IDLE;
          end else begin
            if (read_q)
              M_ReadData = fmt_load(DataMem_In, off_q, byte_q, half_q, sign_q);
            if (M_StallExt) begin
              hold_d  = M_ReadData;
              state_d = S_HOLD;
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          M_Stall_Mem = 1'b1;
        end
      end

      S_HOLD: begin
        M_ReadData = hold_q;
        if (!M_StallExt)
          state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Nothing is issued or reported while reset is held
    if (reset) begin
      DataMem_Address = '0;
      DataMem_Read    = 1'b0;
      DataMem_Write   = 4'b0000;
      DataMem_Out     = '0;
      M_ReadData      = '0;
      M_Stall_Mem     = 1'b0;
      M_EXC_AdEL      = 1'b0;
      M_EXC_AdES      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_dataif.sv
// Directed bench for mem_stage_dataif: zero-latency loads, wait states, hold,
// flush-in-wait, misalignment and asynchronous reset mid-transaction.
module tb_mem_stage_dataif;

  logic        clock = 1'b0;
  logic        reset;
  logic        M_MemRead, M_MemWrite, M_MemByte, M_MemHalf, M_MemSignExtend;
  logic [31:0] M_ALU_Result, M_WriteData;
  logic        M_Flush, M_StallExt;
  logic [31:0] DataMem_In;
  logic        DataMem_Ready;
  logic [29:0] DataMem_Address;
  logic        DataMem_Read;
  logic [3:0]  DataMem_Write;
  logic [31:0] DataMem_Out, M_ReadData;
  logic        M_Stall_Mem, M_EXC_AdEL, M_EXC_AdES;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  mem_stage_dataif #(.ADDR_W(30)) dut (
    .clock(clock), .reset(reset),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_MemByte(M_MemByte),
    .M_MemHalf(M_MemHalf), .M_MemSignExtend(M_MemSignExtend),
    .M_ALU_Result(M_ALU_Result), .M_WriteData(M_WriteData),
    .M_Flush(M_Flush), .M_StallExt(M_StallExt),
    .DataMem_In(DataMem_In), .DataMem_Ready(DataMem_Ready),
    .DataMem_Address(DataMem_Address), .DataMem_Read(DataMem_Read),
    .DataMem_Write(DataMem_Write), .DataMem_Out(DataMem_Out),
    .M_ReadData(M_ReadData), .M_Stall_Mem(M_Stall_Mem),
    .M_EXC_AdEL(M_EXC_AdEL), .M_EXC_AdES(M_EXC_AdES)
  );

  always #5 clock = ~clock;

  task automatic set_idle();
    M_MemRead = 0; M_MemWrite = 0; M_MemByte = 0; M_MemHalf = 0;
    M_MemSignExtend = 0; M_ALU_Result = 0; M_WriteData = 0;
    M_Flush = 0; M_StallExt = 0; DataMem_In = 0; DataMem_Ready = 0;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic b, input logic h,
                        input logic sx, input logic [31:0] addr, input logic [31:0] wd);
    M_MemRead = rd; M_MemWrite = wr; M_MemByte = b; M_MemHalf = h;
    M_MemSignExtend = sx; M_ALU_Result = addr; M_WriteData = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    set_op(1, 0, 0, 0, 0, 32'h0000_0100, 0);
    DataMem_Ready = 1; DataMem_In = 32'hCAFE_F00D;
    #2;
    total_cnt++; if (DataMem_Read !== 1'b0) $display("FAIL rst_read got %b exp 0", DataMem_Read); else pass_cnt++;
    total_cnt++; if (M_ReadData !== 32'h0) $display("FAIL rst_rdata got %h exp 00000000", M_ReadData); else pass_cnt++;
    total_cnt++; if ({M_Stall_Mem, M_EXC_AdEL, M_EXC_AdES, DataMem_Write} !== 7'b0)
      $display("FAIL rst_misc got %b exp 0000000", {M_Stall_Mem, M_EXC_AdEL, M_EXC_AdES, DataMem_Write}); else pass_cnt++;
    @(negedge clock); reset = 1'b0; set_idle();
  endtask

  task automatic test_zero_latency();
    // LB 0x1001 sign-extended
    @(negedge clock);
    set_op(1, 0, 1, 0, 1, 32'h0000_1001, 0);
    DataMem_In = 32'h12F4_5678; DataMem_Ready = 1; #1;
    total_cnt++; if (DataMem_Address !== 30'h400) $display("FAIL lb_addr got %h exp 400", DataMem_Address); else pass_cnt++;
    total_cnt++; if (DataMem_Read !== 1'b1) $display("FAIL lb_read got %b exp 1", DataMem_Read); else pass_cnt++;
    total_cnt++; if (DataMem_Write !== 4'b0) $display("FAIL lb_we got %b exp 0000", DataMem_Write); else pass_cnt++;
    total_cnt++; if (M_ReadData !== 32'hFFFF_FFF4) $display("FAIL lb_rdata got %h exp fffffff4", M_ReadData); else pass_cnt++;
    total_cnt++; if (M_Stall_Mem !== 1'b0) $display("FAIL lb_stall got %b exp 0", M_Stall_Mem); else pass_cnt++;
    // LBU same byte
    @(negedge clock); M_MemSignExtend = 0; #1;
    total_cnt++; if (M_ReadData !== 32'h0000_00F4) $display("FAIL lbu_rdata got %h exp 000000f4", M_ReadData); else pass_cnt++;
    // LB offset 3, positive byte
    @(negedge clock); set_op(1, 0, 1, 0, 1, 32'h0000_1003, 0); #1;
    total_cnt++; if (M_ReadData !== 32'h0000_0078) $display("FAIL lb3_rdata got %h exp 00000078", M_ReadData); else pass_cnt++;
    // LH offset 2, signed
    @(negedge clock); set_op(1, 0, 0, 1, 1, 32'h0000_1002, 0); DataMem_In = 32'h0000_9ABC; #1;
    total_cnt++; if (M_ReadData !== 32'hFFFF_9ABC) $display("FAIL lh_rdata got %h exp ffff9abc", M_ReadData); else pass_cnt++;
    // SB 0x55 at offset 1
    @(negedge clock); set_op(0, 1, 1, 0, 0, 32'h0000_3001, 32'h1234_5655); #1;
    total_cnt++; if (DataMem_Write !== 4'b0100) $display("FAIL sb_we got %b exp 0100", DataMem_Write); else pass_cnt++;
    total_cnt++; if (DataMem_Out !== 32'h5555_5555) $display("FAIL sb_out got %h exp 55555555", DataMem_Out); else pass_cnt++;
    total_cnt++; if (M_ReadData !== 32'h0) $display("FAIL sb_rdata got %h exp 00000000", M_ReadData); else pass_cnt++;
    // SW word
    @(negedge clock); set_op(0, 1, 0, 0, 0, 32'h0000_3004, 32'hDEAD_BEEF); #1;
    total_cnt++; if ({DataMem_Write, DataMem_Out} !== {4'b1111, 32'hDEAD_BEEF})
      $display("FAIL sw_req got %b/%h exp 1111/deadbeef", DataMem_Write, DataMem_Out); else pass_cnt++;
    @(negedge clock); set_idle();
  endtask

  task automatic test_wait_store();
    int stalls = 0;
    @(negedge clock);
    set_op(0, 1, 0, 1, 0, 32'h0000_2002, 32'h0000_ABCD); DataMem_Ready = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) DataMem_Ready = 1;
      #1;
      if (M_Stall_Mem === 1'b1) stalls++;
      total_cnt++;
      if ({DataMem_Address, DataMem_Write, DataMem_Out} !== {30'h800, 4'b0011, 32'hABCD_ABCD})
        $display("FAIL sh_req_c%0d got %h/%b/%h exp 800/0011/abcdabcd", c, DataMem_Address, DataMem_Write, DataMem_Out);
      else pass_cnt++;
      @(negedge clock);
      // Scramble M inputs: the bus must keep the latched request
      set_op(0, 0, 0, 0, 0, 32'h0000_0000, 32'h0);
    end
    total_cnt++; if (stalls != 3) $display("FAIL sh_stall_cycles got %0d exp 3", stalls); else pass_cnt++;
    DataMem_Ready = 0; #1;
    total_cnt++; if ({M_Stall_Mem, DataMem_Write} !== 5'b0) $display("FAIL sh_after got %b exp 00000", {M_Stall_Mem, DataMem_Write}); else pass_cnt++;
    set_idle();
  endtask

  task automatic test_misaligned();
    @(negedge clock); set_op(1, 0, 0, 0, 0, 32'h0000_0006, 0); DataMem_Ready = 1; #1;
    total_cnt++; if ({M_EXC_AdEL, M_EXC_AdES, DataMem_Read, M_Stall_Mem} !== 4'b1000)
      $display("FAIL lw_adel got %b exp 1000", {M_EXC_AdEL, M_EXC_AdES, DataMem_Read, M_Stall_Mem}); else pass_cnt++;
    @(negedge clock); set_idle(); #1;
    total_cnt++; if (M_EXC_AdEL !== 1'b0) $display("FAIL adel_oneshot got %b exp 0", M_EXC_AdEL); else pass_cnt++;
    @(negedge clock); set_op(0, 1, 0, 0, 0, 32'h0000_0001, 32'h1); #1;
    total_cnt++; if ({M_EXC_AdES, M_EXC_AdEL, DataMem_Write} !== 6'b100000)
      $display("FAIL sw_ades got %b exp 100000", {M_EXC_AdES, M_EXC_AdEL, DataMem_Write}); else pass_cnt++;
    @(negedge clock); set_op(1, 0, 0, 1, 0, 32'h0000_0003, 0); #1;
    total_cnt++; if (M_EXC_AdEL !== 1'b1) $display("FAIL lh_adel got %b exp 1", M_EXC_AdEL); else pass_cnt++;
    @(negedge clock); M_MemByte = 1; DataMem_Ready = 1; #1;
    total_cnt++; if ({M_EXC_AdEL, DataMem_Read} !== 2'b01) $display("FAIL lb_noexc got %b exp 01", {M_EXC_AdEL, DataMem_Read}); else pass_cnt++;
    @(negedge clock); set_op(1, 0, 0, 0, 0, 32'h0000_0006, 0); M_Flush = 1; #1;
    total_cnt++; if ({M_EXC_AdEL, DataMem_Read} !== 2'b00) $display("FAIL flush_noexc got %b exp 00", {M_EXC_AdEL, DataMem_Read}); else pass_cnt++;
    @(negedge clock); set_idle();
  endtask

  task automatic test_hold();
    @(negedge clock); set_op(1, 0, 0, 1, 0, 32'h0000_0010, 0); DataMem_Ready = 0; #1;
    total_cnt++; if (M_Stall_Mem !== 1'b1) $display("FAIL lhu_stall got %b exp 1", M_Stall_Mem); else pass_cnt++;
    @(negedge clock); set_op(0, 0, 0, 0, 0, 0, 0);
    DataMem_Ready = 1; DataMem_In = 32'h8001_FFFF; M_StallExt = 1; #1;
    total_cnt++; if ({M_Stall_Mem, M_ReadData} !== {1'b0, 32'h0000_8001})
      $display("FAIL lhu_done got %b/%h exp 0/00008001", M_Stall_Mem, M_ReadData); else pass_cnt++;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock); DataMem_Ready = 0; DataMem_In = 32'h0;
      set_op(1, 0, 0, 0, 0, 32'h0000_0020, 0); #1;
      total_cnt++; if ({DataMem_Read, M_Stall_Mem, M_ReadData} !== {2'b00, 32'h0000_8001})
        $display("FAIL hold_c%0d got %b/%b/%h exp 0/0/00008001", c, DataMem_Read, M_Stall_Mem, M_ReadData); else pass_cnt++;
    end
    @(negedge clock); M_StallExt = 0; #1;
    total_cnt++; if ({DataMem_Read, M_ReadData} !== {1'b0, 32'h0000_8001})
      $display("FAIL hold_release got %b/%h exp 0/00008001", DataMem_Read, M_ReadData); else pass_cnt++;
    @(negedge clock); DataMem_Ready = 1; DataMem_In = 32'h1122_3344; #1;
    total_cnt++; if ({DataMem_Read, DataMem_Address, M_ReadData} !== {1'b1, 30'h8, 32'h1122_3344})
      $display("FAIL hold_next got %b/%h/%h exp 1/8/11223344", DataMem_Read, DataMem_Address, M_ReadData); else pass_cnt++;
    @(negedge clock); set_idle();
  endtask

  task automatic test_flush_wait();
    @(negedge clock); set_op(1, 0, 0, 0, 0, 32'h0000_0040, 0); DataMem_Ready = 0; #1;
    total_cnt++; if (M_Stall_Mem !== 1'b1) $display("FAIL fl_stall0 got %b exp 1", M_Stall_Mem); else pass_cnt++;
    @(negedge clock); set_op(0, 0, 0, 0, 0, 0, 0); M_Flush = 1; #1;
    total_cnt++; if ({M_Stall_Mem, DataMem_Read} !== 2'b11) $display("FAIL fl_stall1 got %b exp 11", {M_Stall_Mem, DataMem_Read}); else pass_cnt++;
    @(negedge clock); M_Flush = 0; #1;
    total_cnt++; if (M_Stall_Mem !== 1'b1) $display("FAIL fl_stall2 got %b exp 1", M_Stall_Mem); else pass_cnt++;
    @(negedge clock); DataMem_Ready = 1; DataMem_In = 32'hDEAD_BEEF; M_StallExt = 1; #1;
    total_cnt++; if ({M_Stall_Mem, M_ReadData} !== {1'b0, 32'h0})
      $display("FAIL fl_done got %b/%h exp 0/00000000", M_Stall_Mem, M_ReadData); else pass_cnt++;
    // Still externally stalled: an aborted access must not park in HOLD
    @(negedge clock); set_op(1, 0, 0, 0, 0, 32'h0000_0044, 0); DataMem_In = 32'h0102_0304; #1;
    total_cnt++; if ({DataMem_Read, DataMem_Address, M_ReadData} !== {1'b1, 30'h11, 32'h0102_0304})
      $display("FAIL fl_next got %b/%h/%h exp 1/11/01020304", DataMem_Read, DataMem_Address, M_ReadData); else pass_cnt++;
    @(negedge clock); set_idle();
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clock); set_op(1, 0, 0, 0, 0, 32'h0000_0080, 0); DataMem_Ready = 0;
    @(posedge clock); #3; reset = 1'b1; #1;
    total_cnt++; if ({DataMem_Read, DataMem_Write, M_Stall_Mem} !== 6'b0)
      $display("FAIL rstw_req got %b exp 000000", {DataMem_Read, DataMem_Write, M_Stall_Mem}); else pass_cnt++;
    @(negedge clock); reset = 1'b0;
    set_op(1, 0, 0, 0, 0, 32'h0000_0084, 0); DataMem_Ready = 1; DataMem_In = 32'h7654_3210; #1;
    total_cnt++; if ({DataMem_Read, M_Stall_Mem, DataMem_Address, M_ReadData} !== {2'b10, 30'h21, 32'h7654_3210})
      $display("FAIL rstw_next got %b/%b/%h/%h exp 1/0/21/76543210", DataMem_Read, M_Stall_Mem, DataMem_Address, M_ReadData); else pass_cnt++;
    @(negedge clock); set_idle();
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_wait_store();
    test_misaligned();
    test_hold();
    test_flush_wait();
    test_reset_mid_wait();
    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_stage_dataif.md
Name: mem_stage_dataif

Overview:
- MEM-stage data-memory interface that sits directly upstream of the MEM/WB pipeline register.
- Converts the M-stage access (address = ALU result, store data, size/sign controls) into a word-addressed, byte-enabled bus request.
- Runs a wait-state handshake with data memory and drives M_ReadData and a MEM stall into the pipeline.
- Formats loaded data (big-endian byte/half/word, sign or zero extension) and flags misaligned accesses as address-error exceptions.

Parameters:
- ADDR_W, 30, word-address width driven onto the data bus (byte address bits [ADDR_W+1:2]).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- M_MemRead  in  1  load in M stage.
- M_MemWrite  in  1  store in M stage.
- M_MemByte  in  1  byte-sized access.
- M_MemHalf  in  1  halfword-sized access; word when both size bits are 0.
- M_MemSignExtend  in  1  sign-extend loaded byte/half.
- M_ALU_Result  in  32  effective byte address.
- M_WriteData  in  32  store data (forwarded value already selected).
- M_Flush  in  1  kill the M-stage access.
- M_StallExt  in  1  MEM stall from other sources.
- DataMem_In  in  32  read data from memory.
- DataMem_Ready  in  1  memory completes current request this cycle.
- DataMem_Address  out  ADDR_W  word address.
- DataMem_Read  out  1  read request.
- DataMem_Write  out  4  byte-lane write enables; [3] = bits 31:24.
- DataMem_Out  out  32  lane-aligned store data.
- M_ReadData  out  32  formatted load result to MEM/WB.
- M_Stall_Mem  out  1  MEM stall caused by this block.
- M_EXC_AdEL  out  1  misaligned load.
- M_EXC_AdES  out  1  misaligned store.

Behaviour:
- Reset (async):
  - State=IDLE; hold register, captured address/offset/size/sign and abort flag cleared.
  - While in reset, all request outputs, M_ReadData, M_Stall_Mem and the exceptions are 0 (no request issued).
- Misalignment (combinational on M inputs):
  - Half with addr[0]=1, or word with addr[1:0]!=0.
  - Raises AdEL (read) or AdES (write) in IDLE; no bus request, no stall.
  - Byte accesses never fault.
- Valid access = (MemRead|MemWrite) & ~misaligned & ~M_Flush, in IDLE.
- Lane mapping (big-endian):
  - Byte at offset k → lane 3-k; store data replicated to all 4 lanes, enable 4'b1000>>k.
  - Half at offset 0 → 4'b1100; offset 2 → 4'b0011; data replicated in both halves.
  - Word → 4'b1111.
  - Write enables are 0 for loads.
- Load format:
  - Selected lane(s) right-justified.
  - Upper bits are copies of the MSB if M_MemSignExtend=1, otherwise 0.
- States:
  - IDLE:
    - Request driven combinationally from M inputs on a valid access.
    - If DataMem_Ready is asserted the same cycle: zero-latency completion. M_ReadData = formatted DataMem_In; stall=0; stay IDLE.
    - If not ready: latch address, offset, size, sign, write enables and data; go to WAIT; M_Stall_Mem=1 this cycle.
  - WAIT:
    - Request driven from the latched copy, held stable; M_Stall_Mem=1 until Ready.
    - On Ready with M_StallExt=0: stall=0, M_ReadData = formatted DataMem_In; next state IDLE.
    - On Ready with M_StallExt=1: stall=0; formatted data captured into the hold register; go to HOLD.
  - HOLD:
    - No request; M_ReadData = hold register; stall=0.
    - Return to IDLE on the first cycle M_StallExt=0; that cycle counts as consumption, so no new request is issued in it.
- Flush:
  - In IDLE: suppresses request and exceptions.
  - In WAIT: bus transaction cannot be cancelled. Set abort flag; keep stalling until Ready, then go to IDLE (never HOLD) and force M_ReadData=0.
  - The abort flag clears on leaving WAIT.
- Reset asserted in WAIT/HOLD returns to IDLE immediately; any outstanding bus transaction is abandoned.
- Outside IDLE, M inputs are ignored except M_Flush and M_StallExt.
- M_ReadData is 0 whenever no load completes or is held.

Test Plan:
- LB from 0x1001 with DataMem_In=0x12F45678, sign=1, Ready same cycle → DataMem_Address=0x0400, Read=1, M_ReadData=0xFFFFFFF4, no stall.
- SH 0xABCD to 0x2002, Ready after 3 cycles → Write=4'b0011, Out=0xABCDABCD held stable for 4 cycles, M_Stall_Mem=1 for exactly 3 cycles.
- LW from 0x0006 → AdEL=1 for one cycle, Read=0, stall=0; SW to 0x0001 → AdES=1, Write=0.
- LHU from 0x0010 with data 0x8001FFFF, Ready in WAIT while M_StallExt=1 for 2 cycles → state HOLD, M_ReadData=0x00008001 stable until M_StallExt falls, then IDLE.
- LW, M_Flush pulsed in WAIT, Ready 2 cycles later → stall held until Ready, M_ReadData=0, returns to IDLE.
- Reset asserted mid-WAIT (asynchronously between clock edges) → Read/Write/stall deassert immediately, state IDLE; a next LW completes normally.
